// File: rtl/rc4_pkg.sv
// Shared RC4 PRGA definitions: FSM state encoding, message defaults and the
// plaintext character filter also used by the checker on the D-RAM side.
package rc4_pkg;

   localparam int         MSG_LEN_DEF = 32;
   localparam logic [7:0] CHAR_A      = 8'h61;
   localparam logic [7:0] CHAR_Z      = 8'h7A;
   localparam logic [7:0] CHAR_SP     = 8'h20;

   typedef enum logic [3:0] {
      IDLE,
      RD_SI,
      WT_SI,
      LD_SI,
      RD_SJ,
      WT_SJ,
      LD_SJ,
      WR_SI,
      WR_SJ,
      RD_F,
      WT_F,
      LD_F,
      WR_D,
      FINISH
   } prga_state_t;

   // Plaintext is accepted only as lowercase letters or space.
   function automatic logic is_valid_char(input logic [7:0] b);
      return ((b >= CHAR_A) && (b <= CHAR_Z)) || (b == CHAR_SP);
   endfunction

endpackage

// File: rtl/rc4_prga_decryptor.sv
// RC4 keystream generator: swaps S-RAM entries, XORs keystream with ROM
// ciphertext and writes plaintext to D-RAM, one byte every 12 cycles.
module rc4_prga_decryptor
   import rc4_pkg::*;
#(
   parameter int MSG_LEN     = MSG_LEN_DEF,
   parameter int ADDR_W      = 5,
   parameter bit EARLY_ABORT = 1'b1
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              Decrypt_Start,
   input  logic              Finish_ack,
   output logic              Decrypt_Finish,
   output logic              Decrypt_Bad,
   output logic [7:0]        S_addr,
   output logic [7:0]        S_data,
   output logic              S_wren,
   input  logic [7:0]        S_q,
   output logic [ADDR_W-1:0] ROM_addr,
   input  logic [7:0]        ROM_q,
   output logic [ADDR_W-1:0] D_addr,
   output logic [7:0]        D_data,
   output logic              D_wren,
   output prga_state_t       dbg_state
);

   // Handshake: Decrypt_Start is a one-cycle pulse honoured only in IDLE;
   // Decrypt_Finish stays high in FINISH until Finish_ack is seen there.
   localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

   prga_state_t       state;
   logic [7:0]        i, j, si, sj, f, c;
   logic [ADDR_W-1:0] k;

   assign dbg_state = state;

   // Outputs are registered: each branch loads the values the next state drives.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         i              <= 8'd1;
         j              <= 8'd0;
         k              <= '0;
         si             <= 8'd0;
         sj             <= 8'd0;
         f              <= 8'd0;
         c              <= 8'd0;
         Decrypt_Finish <= 1'b0;
         Decrypt_Bad    <= 1'b0;
         S_addr         <= 8'd0;
         S_data         <= 8'd0;
         S_wren         <= 1'b0;
         ROM_addr       <= '0;
         D_addr         <= '0;
         D_data         <= 8'd0;
         D_wren         <= 1'b0;
      end else begin
         S_wren <= 1'b0;
         D_wren <= 1'b0;
         case (state)
            IDLE: begin
               if (Decrypt_Start) begin
                  state       <= RD_SI;
                  i           <= 8'd1;
                  j           <= 8'd0;
                  k           <= '0;
                  Decrypt_Bad <= 1'b0;
                  S_addr      <= 8'd1;
               end
            end
            RD_SI: state <= WT_SI;
            WT_SI: state <= LD_SI;
            LD_SI: begin
               si     <= S_q;
               j      <= j + S_q;
               S_addr <= j + S_q;
               state  <= RD_SJ;
            end
            RD_SJ: state <= WT_SJ;
            WT_SJ: state <= LD_SJ;
            LD_SJ: begin
               sj     <= S_q;
               S_addr <= i;
               S_data <= S_q;
               S_wren <= 1'b1;
               state  <= WR_SI;
            end
            WR_SI: begin
               S_addr <= j;
               S_data <= si;
               S_wren <= 1'b1;
               state  <= WR_SJ;
            end
            WR_SJ: begin
               S_addr   <= si + sj;
               ROM_addr <= k;
               state    <= RD_F;
            end
            RD_F: state <= WT_F;
            WT_F: state <= LD_F;
            LD_F: begin
               f      <= S_q;
               c      <= ROM_q;
               D_addr <= k;
               D_data <= S_q ^ ROM_q;
               D_wren <= 1'b1;
               state  <= WR_D;
            end
            WR_D: begin
               i <= i + 8'd1;
               if (EARLY_ABORT && !is_valid_char(f ^ c)) begin
                  Decrypt_Bad    <= 1'b1;
                  Decrypt_Finish <= 1'b1;
                  state          <= FINISH;
               end else if (k == LAST_K) begin
                  Decrypt_Finish <= 1'b1;
                  state          <= FINISH;
               end else begin
                  // k only advances when another byte follows, so it stays in range.
                  k      <= k + 1'b1;
                  S_addr <= i + 8'd1;
                  state  <= RD_SI;
               end
            end
            FINISH: begin
               if (Finish_ack) begin
                  Decrypt_Finish <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Bench for rc4_prga_decryptor: two instances (full-length, and 2-byte with
// early abort) on behavioural memories, checked against a software RC4 model.
module tb_rc4_prga_decryptor;
   import rc4_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- DUT signals (index 0: full, 1: abort) ----------------
   logic        start[2], ack[2], fin[2], bad[2], s_wren[2], d_wren[2];
   logic [7:0]  s_addr[2], s_data[2], s_q[2], rom_q[2], d_data[2];
   logic [4:0]  rom_addr[2], d_addr[2];
   prga_state_t dbg_state[2];

   logic [7:0]  s_mem[2][256];
   logic [7:0]  rom[2][32];
   logic [7:0]  d_mem[2][32];
   int          d_writes[2];
   logic [15:0] snap23;
   logic        ld_req[2];
   logic [7:0]  ld_s[256];
   logic [7:0]  ld_rom[32];

   logic [7:0]  exp_q[$];
   logic [7:0]  exp_s[256];
   int          n_vec = 0;
   int          n_err = 0;

   rc4_prga_decryptor #(.MSG_LEN(32), .ADDR_W(5), .EARLY_ABORT(1'b0)) dut_full (
      .CLOCK_50(clk), .rst_n(rst_n), .Decrypt_Start(start[0]), .Finish_ack(ack[0]),
      .Decrypt_Finish(fin[0]), .Decrypt_Bad(bad[0]), .S_addr(s_addr[0]), .S_data(s_data[0]),
      .S_wren(s_wren[0]), .S_q(s_q[0]), .ROM_addr(rom_addr[0]), .ROM_q(rom_q[0]),
      .D_addr(d_addr[0]), .D_data(d_data[0]), .D_wren(d_wren[0]), .dbg_state(dbg_state[0]));

   rc4_prga_decryptor #(.MSG_LEN(2), .ADDR_W(5), .EARLY_ABORT(1'b1)) dut_abort (
      .CLOCK_50(clk), .rst_n(rst_n), .Decrypt_Start(start[1]), .Finish_ack(ack[1]),
      .Decrypt_Finish(fin[1]), .Decrypt_Bad(bad[1]), .S_addr(s_addr[1]), .S_data(s_data[1]),
      .S_wren(s_wren[1]), .S_q(s_q[1]), .ROM_addr(rom_addr[1]), .ROM_q(rom_q[1]),
      .D_addr(d_addr[1]), .D_data(d_data[1]), .D_wren(d_wren[1]), .dbg_state(dbg_state[1]));

   // ---------------- memory models: one-cycle read latency ----------------
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (ld_req[u]) begin
            for (int a = 0; a < 256; a++) s_mem[u][a] <= ld_s[a];
            for (int a = 0; a < 32; a++) begin
               rom[u][a]   <= ld_rom[a];
               d_mem[u][a] <= 8'h00;
            end
         end else begin
            if (s_wren[u]) s_mem[u][s_addr[u]] <= s_data[u];
            if (d_wren[u]) begin
               d_mem[u][d_addr[u]] <= d_data[u];
               d_writes[u]         <= d_writes[u] + 1;
            end
         end
         s_q[u]   <= s_mem[u][s_addr[u]];
         rom_q[u] <= rom[u][rom_addr[u]];
      end
      if (d_wren[0] && d_addr[0] == 5'd1) snap23 <= {s_mem[0][2], s_mem[0][3]};
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int u);
      ld_req[u] = 1'b1;
      tick();
      ld_req[u] = 1'b0;
   endtask

   task automatic identity();
      for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
      for (int a = 0; a < 32; a++) ld_rom[a] = 8'h00;
   endtask

   task automatic ksa(input int keylen);
      int key[16];
      int jj;
      logic [7:0] t;
      for (int a = 0; a < 16; a++) key[a] = $urandom_range(0, 255);
      for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
      jj = 0;
      for (int x = 0; x < 256; x++) begin
         jj = (jj + int'(ld_s[x]) + key[x % keylen]) % 256;
         t = ld_s[x]; ld_s[x] = ld_s[jj]; ld_s[jj] = t;
      end
   endtask

   function automatic bit char_ok(input int p);
      return (p >= 97 && p <= 122) || p == 32;
   endfunction

   // Textbook RC4 PRGA over the staged S-box and ciphertext.
   task automatic model(input int len, input bit ea, output int n, output bit bd);
      int ms[256];
      int ii, jj, t, ks, p;
      for (int x = 0; x < 256; x++) ms[x] = int'(ld_s[x]);
      exp_q.delete();
      ii = 0; jj = 0; n = 0; bd = 1'b0;
      for (int kk = 0; kk < len; kk++) begin
         ii = (ii + 1) % 256;
         jj = (jj + ms[ii]) % 256;
         t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
         ks = ms[(ms[ii] + ms[jj]) % 256];
         p = ks ^ int'(ld_rom[kk]);
         exp_q.push_back(8'(p));
         n++;
         if (ea && !char_ok(p)) begin
            bd = 1'b1;
            break;
         end
      end
      for (int x = 0; x < 256; x++) exp_s[x] = 8'(ms[x]);
   endtask

   task automatic run(input int u, input bit poke, output int cyc);
      start[u] = 1'b1;
      tick();
      start[u] = 1'b0;
      cyc = 1;
      while (!fin[u] && cyc < 2000) begin
         if (poke && cyc == 50) begin
            start[u] = 1'b1; ack[u] = 1'b1;
         end else begin
            start[u] = 1'b0; ack[u] = 1'b0;
         end
         tick();
         cyc++;
      end
      start[u] = 1'b0; ack[u] = 1'b0;
      check($sformatf("finish_seen_u%0d", u), 64'(fin[u]), 64'd1);
   endtask

   task automatic release_fin(input int u, input int hold, input string tag);
      ack[u]   = 1'b1;
      start[u] = (hold > 1);
      tick();
      start[u] = 1'b0;
      for (int h = 1; h < hold; h++) tick();
      ack[u] = 1'b0;
      tick();
      check({tag, "_idle"}, 64'(dbg_state[u]), 64'(IDLE));
      check({tag, "_fin_low"}, 64'(fin[u]), 64'd0);
   endtask

   task automatic do_test(input int u, input int len, input bit ea, input bit poke,
                          input int hold, input string tag, output int cyc, output bit bd);
      int n, base, nw;
      load(u);
      model(len, ea, n, bd);
      base = d_writes[u];
      run(u, poke, cyc);
      nw = d_writes[u] - base;
      check({tag, "_lat"}, 64'(cyc), 64'(12 * n + 1));
      check({tag, "_nwr"}, 64'(nw), 64'(n));
      check({tag, "_bad"}, 64'(bad[u]), 64'(bd));
      for (int kk = 0; kk < n; kk++)
         check($sformatf("%s_d%0d", tag, kk), 64'(d_mem[u][kk]), 64'(exp_q.pop_front()));
      for (int x = 0; x < 256; x++)
         check($sformatf("%s_s%0d", tag, x), 64'(s_mem[u][x]), 64'(exp_s[x]));
      release_fin(u, hold, tag);
   endtask

   function automatic logic [63:0] outs(input int u);
      return 64'({s_addr[u], s_data[u], s_wren[u], rom_addr[u], d_addr[u],
                  d_data[u], d_wren[u], fin[u], bad[u]});
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int cyc, cnt, base, n;
      bit bd;
      logic [7:0] ks[2];
      int ch;

      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         start[u] = 1'b0; ack[u] = 1'b0; ld_req[u] = 1'b0;
      end
      tick(); tick(); tick();
      for (int u = 0; u < 2; u++) begin
         check($sformatf("rst_outs_u%0d", u), outs(u), 64'd0);
         check($sformatf("rst_state_u%0d", u), 64'(dbg_state[u]), 64'(IDLE));
      end
      rst_n = 1'b1;
      tick();

      // identity S, zero ciphertext, full length
      identity();
      do_test(0, 32, 1'b0, 1'b0, 1, "s1", cyc, bd);
      check("s1_cycles", 64'(cyc), 64'd385);
      check("s1_d0", 64'(d_mem[0][0]), 64'h02);
      check("s1_d1", 64'(d_mem[0][1]), 64'h05);
      check("s1_swap23", 64'(snap23), 64'h0302);

      // two lowercase bytes, no abort
      identity();
      ld_rom[0] = 8'h63; ld_rom[1] = 8'h64;
      do_test(1, 2, 1'b1, 1'b0, 1, "s2", cyc, bd);
      check("s2_d0", 64'(d_mem[1][0]), 64'h61);
      check("s2_d1", 64'(d_mem[1][1]), 64'h61);
      check("s2_bad", 64'(bad[1]), 64'd0);

      // first byte invalid: abort after one write
      identity();
      do_test(1, 2, 1'b1, 1'b0, 1, "s3", cyc, bd);
      check("s3_cycles", 64'(cyc), 64'd13);
      check("s3_bad", 64'(bad[1]), 64'd1);
      check("s3_d0", 64'(d_mem[1][0]), 64'h02);

      // stray start/ack mid-run, ack held three cycles with a start in FINISH
      identity();
      do_test(0, 32, 1'b0, 1'b1, 3, "s4", cyc, bd);
      base = d_writes[0];
      for (int h = 0; h < 5; h++) tick();
      check("s4_still_idle", 64'(dbg_state[0]), 64'(IDLE));
      check("s4_no_rerun", 64'(d_writes[0] - base), 64'd0);

      // reset in WR_SI of byte 5
      identity();
      load(0);
      base = d_writes[0];
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      cnt = 0; cyc = 0;
      while (cnt < 5 && cyc < 2000) begin
         if (dbg_state[0] == WR_SI) cnt++;
         if (cnt < 5) begin
            tick();
            cyc++;
         end
      end
      check("s5_reached", 64'(cnt), 64'd5);
      check("s5_wren_before", 64'(s_wren[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      check("s5_outs", outs(0), 64'd0);
      check("s5_state", 64'(dbg_state[0]), 64'(IDLE));
      check("s5_nwr", 64'(d_writes[0] - base), 64'd4);
      tick(); tick();
      check("s5_outs_held", outs(0), 64'd0);
      rst_n = 1'b1;
      tick();
      identity();
      do_test(0, 32, 1'b0, 1'b0, 1, "s5r", cyc, bd);
      check("s5r_d0", 64'(d_mem[0][0]), 64'h02);
      check("s5r_d1", 64'(d_mem[0][1]), 64'h05);

      // random keys against the software model, full length
      for (int t = 0; t < 3; t++) begin
         ksa($urandom_range(3, 16));
         for (int a = 0; a < 32; a++) ld_rom[a] = 8'($urandom_range(0, 255));
         do_test(0, 32, 1'b0, 1'b0, 1, $sformatf("rk%0d", t), cyc, bd);
      end

      // random keys with chosen plaintext validity on the abort instance
      for (int t = 0; t < 6; t++) begin
         ksa($urandom_range(3, 16));
         for (int a = 0; a < 32; a++) ld_rom[a] = 8'h00;
         model(2, 1'b0, n, bd);
         ks[0] = exp_q.pop_front();
         ks[1] = exp_q.pop_front();
         for (int a = 0; a < 2; a++) begin
            if ($urandom_range(0, 3) != 0) begin
               ch = ($urandom_range(0, 26) == 26) ? 32 : 97 + $urandom_range(0, 25);
            end else begin
               ch = $urandom_range(0, 255);
               while (char_ok(ch)) ch = $urandom_range(0, 255);
            end
            ld_rom[a] = ks[a] ^ 8'(ch);
         end
         do_test(1, 2, 1'b1, 1'b0, 1, $sformatf("ra%0d", t), cyc, bd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
